// File: rtl/fann_pkg.sv
// Shared fan-in/fan-out datapath definitions: default lane geometry used by both
// the aggregator and the disaggregator, plus the common holding-buffer state.
package fann_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 16;
  localparam int unsigned DEF_FETCH_WIDTH = 4;

  // Holding buffer occupancy: EMPTY has no word, DRAIN is emitting lanes.
  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } fann_state_e;

endpackage

// File: rtl/disaggregator.sv
// Wide-to-narrow serializer. Pops one FETCH_WIDTH*DATA_WIDTH word from the
// upstream FIFO and pushes its lanes, lane 0 (LSBs) first, to the downstream FIFO.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   clr               sync clear, drops the buffered word
//   sender_data       upstream FIFO head (wide)
//   sender_empty_n    upstream FIFO non-empty
//   sender_deq        upstream pop, data captured on the same edge
//   receiver_data     current lane of the buffered word
//   receiver_full_n   downstream FIFO has room
//   receiver_enq      downstream push
//   receiver_last     current lane is the last of its wide word
module disaggregator
  import fann_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned FETCH_WIDTH = DEF_FETCH_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clr,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [DATA_WIDTH-1:0]             receiver_data,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq,
  output logic                              receiver_last
);

  localparam int unsigned IDX_WIDTH = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FETCH_WIDTH - 1);

  fann_state_e                             state_q, state_d;
  logic [IDX_WIDTH-1:0]                    idx_q, idx_d;
  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0]  buf_q, buf_d;

  logic full;
  logic last_pop;

  // State, lane counter and holding buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  // Handshakes. rst_n gates the pop so nothing is taken from the FIFO while
  // the block is held in reset; the receive side is already idle in EMPTY.
  always_comb begin
    full          = (state_q == DRAIN);
    receiver_data = buf_q[idx_q];
    receiver_last = full && (idx_q == LAST_IDX);
    receiver_enq  = full && receiver_full_n && !clr;
    last_pop      = receiver_enq && receiver_last;
    sender_deq    = rst_n && sender_empty_n && !clr && (!full || last_pop);
  end

  // Next state: clr dominates, then a load (fresh or back-to-back), then drain.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    if (clr) begin
      state_d = EMPTY;
      idx_d   = '0;
    end else if (sender_deq) begin
      state_d = DRAIN;
      idx_d   = '0;
      buf_d   = sender_data;
    end else if (last_pop) begin
      state_d = EMPTY;
      idx_d   = '0;
    end else if (receiver_enq) begin
      idx_d   = idx_q + IDX_WIDTH'(1);
    end
  end

endmodule

// File: doc/disaggregator.md
Name: disaggregator

Overview:
Wide-to-narrow serializer: accepts one FETCH_WIDTH*DATA_WIDTH word from an upstream FIFO and emits its FETCH_WIDTH lanes one DATA_WIDTH word at a time, lane 0 (LSBs) first, to a downstream FIFO. It is the inverse of the aggregator and sits on the output side of the wide datapath, feeding narrow result FIFOs. The packing order matches the aggregator: aggregator followed by disaggregator is an identity transform on the word stream.

Parameters:
DATA_WIDTH, 16, width of one narrow output word
FETCH_WIDTH, 4, narrow words per wide input word (>=1)
IDX_WIDTH, $clog2(FETCH_WIDTH) (min 1), lane counter width; derived, not overridden

Ports:
clk  in  1  single clock, all state on posedge
rst_n  in  1  asynchronous, active-low reset
clr  in  1  synchronous clear; discards the buffered word
sender_data  in  FETCH_WIDTH*DATA_WIDTH  upstream FIFO head; valid whenever sender_empty_n=1
sender_empty_n  in  1  upstream FIFO holds a word
sender_deq  out  1  pop upstream FIFO; sender_data captured on the same edge
receiver_data  out  DATA_WIDTH  current lane of the buffered word
receiver_full_n  in  1  downstream FIFO can accept a word
receiver_enq  out  1  push receiver_data this cycle
receiver_last  out  1  receiver_data is lane FETCH_WIDTH-1 of its wide word

Behaviour:
- State: wide holding register buf, lane counter idx, flag full (states EMPTY: full=0; DRAIN: full=1).
- Reset (rst_n=0, async): full=0, idx=0, buf=0. Outputs during reset: sender_deq=0, receiver_enq=0, receiver_last=0, receiver_data=0.
- receiver_data = buf[idx*DATA_WIDTH +: DATA_WIDTH] (combinational from registers).
- receiver_enq = full && receiver_full_n && !clr.
- receiver_last = full && (idx == FETCH_WIDTH-1).
- last_pop = receiver_enq && receiver_last.
- sender_deq = sender_empty_n && !clr && (!full || last_pop). Combinational; never asserted when sender_empty_n=0.
- Transitions:
  - EMPTY, sender_deq -> DRAIN; buf<=sender_data, idx<=0.
  - DRAIN, receiver_enq, not last -> idx<=idx+1.
  - DRAIN, last_pop and sender_deq -> stay in DRAIN; buf<=sender_data, idx<=0. Back-to-back, no bubble.
  - DRAIN, last_pop without sender_deq -> EMPTY; idx<=0.
  - DRAIN, receiver_full_n=0 -> hold buf and idx; receiver_data stays stable.
- Latency: wide word popped at edge N; lane 0 enqueued in cycle N+1 if receiver_full_n=1.
- Sustained throughput: one narrow word per cycle. Wide words are consumed at one per FETCH_WIDTH cycles.
- idx wraps only through the last_pop path. idx never exceeds FETCH_WIDTH-1.
- FETCH_WIDTH=1: idx is constant 0, receiver_last=full. The block becomes a one-deep pipeline register with full throughput.
- clr=1: next state is full=0, idx=0. sender_deq and receiver_enq are forced 0 that cycle. clr wins over any simultaneous handshake. Remaining lanes are dropped, with no partial word emitted afterwards.
- Reset asserted mid-drain: immediate return to EMPTY and remaining lanes are lost. The reset generator is responsible for resetting the FIFOs alongside.
- No combinational path from receiver_full_n to sender_deq except through last_pop. This is intentional and documented; upstream FIFO deq logic must tolerate it.

Decomposition:
- Shared package (fann_pkg): default DATA_WIDTH and FETCH_WIDTH constants shared with the aggregator, and the state typedef enum {EMPTY, DRAIN}.
- No sub-module. Lane select is a single indexed part-select. Counter and flag are inline. Target is roughly 120-150 lines.

Test Plan:
- Reset: rst_n=0 with sender_empty_n=1 -> sender_deq=0, receiver_enq=0, receiver_last=0. After release, the first pop occurs on the first enabled edge.
- Single word: sender_data=0x0003_0002_0001_0000, receiver_full_n=1 -> receiver_data 0,1,2,3 on four consecutive cycles starting the cycle after the pop. receiver_last high only on 3. Then EMPTY.
- Back-to-back: upstream always non-empty with words {4k+3..4k} -> continuous output 0,1,2,…,63 with no idle cycle. sender_deq is asserted exactly on the cycles where lane 3 is enqueued.
- Backpressure: random receiver_full_n (50%) and random upstream empty -> output sequence strictly incrementing, with no duplicates or drops. receiver_data is stable while receiver_full_n=0.
- clr mid-drain: assert clr after lane 1 of word 0x0003_0002_0001_0000 -> lanes 2 and 3 are never emitted, sender_deq=0 that cycle. The next word restarts at lane 0.
- Round trip: aggregator -> FIFO(depth 3) -> disaggregator with a 16-bit counter source and random stalls on both ends -> output equals input counter sequence 0..N, and the assert passes for 2000 ns.
